// File: rtl/b_dly_cal.sv
// Delay-line select calibration: binary search for the phase-detector transition,
// then +/-1 code tracking with majority-voted early/late decisions.
module b_dly_cal #(
  parameter int DW         = 8,
  parameter int SETTLE_CYC = 16,
  parameter int SAMPLE_N   = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_hold,
  input  logic          i_pd_early,
  output logic [DW-1:0] o_dly_sel,
  output logic          o_busy,
  output logic          o_lock,
  output logic          o_err
);

  localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_N) ? SETTLE_CYC : SAMPLE_N;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int VW      = $clog2(SAMPLE_N + 1);
  localparam int BW      = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [DW-1:0] CODE_MID    = DW'(1) << (DW - 1);
  localparam logic [DW-1:0] CODE_MAX    = '1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_N - 1);
  localparam logic [VW-1:0] VOTE_HALF   = VW'(SAMPLE_N / 2);
  localparam logic [BW-1:0] BIT_TOP     = BW'(DW - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DECIDE} state_t;
  typedef enum logic {SEARCH, TRACK} phase_t;

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [BW-1:0] bit_idx, bit_idx_n;
  logic [DW-1:0] result, result_n;
  logic [DW-1:0] sel, sel_n;
  logic          busy, busy_n;
  logic          lock, lock_n;
  logic          err, err_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [VW-1:0] votes, votes_n;

  logic          early;
  logic [DW-1:0] kept;

  // A tie in the vote counts as late.
  assign early = (votes > VOTE_HALF);
  assign kept  = early ? (result | (DW'(1) << bit_idx)) : result;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    bit_idx_n = bit_idx;
    result_n  = result;
    sel_n     = sel;
    busy_n    = busy;
    lock_n    = lock;
    err_n     = err;
    cnt_n     = cnt;
    votes_n   = votes;

    unique case (state)
      IDLE: ;
      SETTLE: begin
        cnt_n = cnt + CW'(1);
        if (cnt == SETTLE_LAST) begin
          state_n = SAMPLE;
          cnt_n   = '0;
          votes_n = '0;
        end
      end
      SAMPLE: begin
        votes_n = votes + VW'(i_pd_early);
        cnt_n   = cnt + CW'(1);
        if (cnt == SAMPLE_LAST) begin
          state_n = DECIDE;
          cnt_n   = '0;
        end
      end
      DECIDE: begin
        state_n = SETTLE;
        if (phase == SEARCH) begin
          result_n = kept;
          if (bit_idx != '0) begin
            bit_idx_n = bit_idx - BW'(1);
            sel_n     = kept | (DW'(1) << (bit_idx - BW'(1)));
          end else begin
            sel_n   = kept;
            busy_n  = 1'b0;
            lock_n  = 1'b1;
            phase_n = TRACK;
            if (kept == '0 || kept == CODE_MAX) err_n = 1'b1;
          end
        end else if (!i_hold) begin
          // Steps past either end leave the code pinned and flag the error.
          if (early) begin
            if (sel == CODE_MAX) err_n = 1'b1;
            else                 sel_n = sel + DW'(1);
          end else begin
            if (sel == '0) err_n = 1'b1;
            else           sel_n = sel - DW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Start is honoured from IDLE or while locked; during a search it is ignored.
    if (i_start && (state == IDLE || lock)) begin
      state_n   = SETTLE;
      phase_n   = SEARCH;
      bit_idx_n = BIT_TOP;
      result_n  = '0;
      sel_n     = CODE_MID;
      busy_n    = 1'b1;
      lock_n    = 1'b0;
      err_n     = 1'b0;
      cnt_n     = '0;
      votes_n   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      phase   <= SEARCH;
      bit_idx <= BIT_TOP;
      result  <= '0;
      sel     <= CODE_MID;
      busy    <= 1'b0;
      lock    <= 1'b0;
      err     <= 1'b0;
      cnt     <= '0;
      votes   <= '0;
    end else begin
      state   <= state_n;
      phase   <= phase_n;
      bit_idx <= bit_idx_n;
      result  <= result_n;
      sel     <= sel_n;
      busy    <= busy_n;
      lock    <= lock_n;
      err     <= err_n;
      cnt     <= cnt_n;
      votes   <= votes_n;
    end
  end

  assign o_dly_sel = sel;
  assign o_busy    = busy;
  assign o_lock    = lock;
  assign o_err     = err;

endmodule

// File: tb/tb_b_dly_cal.sv
// Directed bench for b_dly_cal: table of search outcomes plus hand sequences for
// tracking, hold, restart, reset abort, limits and majority voting.
module tb_b_dly_cal;

  localparam int MODE_THR    = 0;  // early when code <= threshold
  localparam int MODE_EARLY  = 1;
  localparam int MODE_LATE   = 2;
  localparam int MODE_MANUAL = 3;  // bench drives i_pd_early directly

  logic       clk = 1'b0;
  logic       rst, start, hold, pd;
  logic [7:0] sel;
  logic       busy, lock, err;

  int         checks   = 0;
  int         failures = 0;
  int         mode     = MODE_THR;
  logic [7:0] thr      = 8'h5A;

  b_dly_cal dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_hold     (hold),
    .i_pd_early (pd),
    .o_dly_sel  (sel),
    .o_busy     (busy),
    .o_lock     (lock),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         mode;
    logic [7:0] thr;
    logic [7:0] exp_sel;
    logic       exp_err;
  } search_vec_t;

  search_vec_t vecs[7];
  logic [7:0]  trials[8];

  function automatic logic model_pd(input logic [7:0] code);
    case (mode)
      MODE_THR:   return (code <= thr);
      MODE_EARLY: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] e_sel, input logic e_busy,
                           input logic e_lock, input logic e_err);
    check({name, ".sel"},  sel,  e_sel);
    check({name, ".busy"}, busy, e_busy);
    check({name, ".lock"}, lock, e_lock);
    check({name, ".err"},  err,  e_err);
  endtask

  // Advance n cycles; outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (mode != MODE_MANUAL) pd = model_pd(sel);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  // Start sampled at edge "cycle 0"; returns at cycle 1.
  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic majority(input logic [7:0] pattern, input logic filler, input logic [7:0] exp_sel,
                          input string name);
    mode = MODE_MANUAL;
    do_reset();
    pd = filler;
    do_start();
    tick(16);
    for (int i = 0; i < 8; i++) begin
      pd = pattern[i];
      tick(1);
    end
    pd = filler;
    tick(1);
    check(name, sel, exp_sel);
  endtask

  initial begin
    vecs[0] = '{MODE_THR,   8'h5A, 8'h5A, 1'b0};
    vecs[1] = '{MODE_EARLY, 8'h00, 8'hFF, 1'b1};
    vecs[2] = '{MODE_LATE,  8'h00, 8'h00, 1'b1};
    vecs[3] = '{MODE_THR,   8'h7F, 8'h7F, 1'b0};
    vecs[4] = '{MODE_THR,   8'h80, 8'h80, 1'b0};
    vecs[5] = '{MODE_THR,   8'hC3, 8'hC3, 1'b0};
    vecs[6] = '{MODE_THR,   8'hFE, 8'hFE, 1'b0};
    trials  = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};

    rst = 1'b1; start = 1'b0; hold = 1'b0; pd = 1'b0;

    // Reset state and idling without start.
    do_reset();
    check_out("reset", 8'h80, 1'b0, 1'b0, 1'b0);
    tick(5);
    check_out("idle", 8'h80, 1'b0, 1'b0, 1'b0);

    // Table: final lock code and error flag for several detector models.
    for (int v = 0; v < 7; v++) begin
      mode = vecs[v].mode;
      thr  = vecs[v].thr;
      do_reset();
      do_start();
      check_out($sformatf("vec%0d.c1", v), 8'h80, 1'b1, 1'b0, 1'b0);
      tick(199);
      check_out($sformatf("vec%0d.c200", v), sel, 1'b1, 1'b0, 1'b0);
      tick(1);
      check_out($sformatf("vec%0d.c201", v), vecs[v].exp_sel, 1'b0, 1'b1, vecs[v].exp_err);
    end

    // Trial-code sequence, stable across each step, then dither and hold.
    mode = MODE_THR; thr = 8'h5A;
    do_reset();
    do_start();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("trial%0d.first", k), sel, trials[k]);
      tick(24);
      check($sformatf("trial%0d.last", k), sel, trials[k]);
      tick(1);
    end
    check_out("search.lock", 8'h5A, 1'b0, 1'b1, 1'b0);
    tick(25);
    check("dither.226", sel, 8'h5B);
    tick(25);
    check("dither.251", sel, 8'h5A);
    tick(25);
    check("dither.276", sel, 8'h5B);
    hold = 1'b1;
    tick(50);
    check("hold.326", sel, 8'h5B);
    hold = 1'b0;
    tick(25);
    check_out("release.351", 8'h5A, 1'b0, 1'b1, 1'b0);

    // Restart while locked.
    do_start();
    check_out("relock.c1", 8'h80, 1'b1, 1'b0, 1'b0);
    tick(199);
    check("relock.c200.lock", lock, 1'b0);
    tick(1);
    check_out("relock.c201", 8'h5A, 1'b0, 1'b1, 1'b0);

    // Start during search is ignored.
    do_reset();
    do_start();
    tick(29);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_out("busy_start.c31", 8'h40, 1'b1, 1'b0, 1'b0);
    tick(170);
    check_out("busy_start.c201", 8'h5A, 1'b0, 1'b1, 1'b0);

    // Lower limit: pinned at 0x00, then reset clears the sticky error.
    mode = MODE_LATE;
    do_reset();
    do_start();
    tick(200);
    check_out("late.lock", 8'h00, 1'b0, 1'b1, 1'b1);
    tick(50);
    check_out("late.track", 8'h00, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_out("late.reset", 8'h80, 1'b0, 1'b0, 1'b0);

    // Upper limit: pinned at 0xFF, accepted start clears the error.
    mode = MODE_EARLY;
    do_reset();
    do_start();
    tick(250);
    check_out("early.track", 8'hFF, 1'b0, 1'b1, 1'b1);
    mode = MODE_THR; thr = 8'h5A;
    do_start();
    check_out("early.restart", 8'h80, 1'b1, 1'b0, 1'b0);

    // Reset mid-search aborts immediately.
    do_reset();
    do_start();
    tick(59);
    check_out("abort.c60", 8'h60, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_out("abort.c61", 8'h80, 1'b0, 1'b0, 1'b0);
    tick(30);
    check_out("abort.stay", 8'h80, 1'b0, 1'b0, 1'b0);

    // Majority vote: 4 of 8 is late, 5 of 8 is early; settle samples ignored.
    majority(8'b1010_1010, 1'b1, 8'h40, "vote4");
    majority(8'b1101_0101, 1'b0, 8'hC0, "vote5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
